// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit with per-register load-latency scoreboard and memory freeze.
// Define HAZ_PERF_CNT_EN to add the stall_cycles performance counter.
module hazard_scoreboard_unit #(
    parameter int REG_W    = 4,
    parameter int LOAD_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] SrcReg1,
    input  logic [REG_W-1:0] SrcReg2,
    input  logic             MemWrite,
    input  logic             Branch,
    input  logic             BR,
    input  logic             update_PC,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemEnable,
    input  logic             ID_EX_MemWrite,
    input  logic             ID_EX_Z_en,
    input  logic             ID_EX_NV_en,
    input  logic [REG_W-1:0] ID_EX_reg_rd,
    input  logic             EX_MEM_RegWrite,
    input  logic [REG_W-1:0] EX_MEM_reg_rd,
    input  logic             mem_busy,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             ID_flush,
    output logic             IF_flush,
`ifdef HAZ_PERF_CNT_EN
    output logic             pipe_freeze,
    output logic [31:0]      stall_cycles
`else
    output logic             pipe_freeze
`endif
);

    localparam int NREG = 1 << REG_W;
    localparam logic [2:0] LAT = 3'(LOAD_LAT);
    localparam logic [REG_W-1:0] R0 = '0;

    logic [2:0] cnt [NREG];

    logic ex_load;
    logic ld_hit1, ld_hit2;
    logic busy1, busy2, st_busy2;
    logic flag_haz, ex_fwd1, mem_fwd1;
    logic lu_haz, b_haz, br_haz, haz;

    assign ex_load  = ID_EX_MemEnable & ~ID_EX_MemWrite & (ID_EX_reg_rd != R0);
    assign ld_hit1  = ex_load & (ID_EX_reg_rd == SrcReg1);
    assign ld_hit2  = ex_load & (ID_EX_reg_rd == SrcReg2);
    assign busy1    = ld_hit1 | (cnt[SrcReg1] != 3'd0);
    assign busy2    = ld_hit2 | (cnt[SrcReg2] != 3'd0);
    // store data can still be forwarded MEM-to-MEM one cycle later
    assign st_busy2 = (ld_hit2 & (LAT != 3'd0)) | (cnt[SrcReg2] > 3'd1);
    assign lu_haz   = busy1 | (MemWrite ? st_busy2 : busy2);

    assign flag_haz = ID_EX_Z_en | ID_EX_NV_en;
    assign ex_fwd1  = ID_EX_RegWrite & (ID_EX_reg_rd != R0)
                    & (ID_EX_reg_rd == SrcReg1);
    assign mem_fwd1 = EX_MEM_RegWrite & (EX_MEM_reg_rd != R0)
                    & (EX_MEM_reg_rd == SrcReg1);
    assign b_haz    = Branch & flag_haz;
    assign br_haz   = Branch & BR
                    & (flag_haz | ex_fwd1 | mem_fwd1 | (cnt[SrcReg1] != 3'd0));
    assign haz      = lu_haz | b_haz | br_haz;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= 3'd0;
        end else if (!mem_busy) begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0)
                    cnt[r] <= 3'd0;
                else if (ex_load && (ID_EX_reg_rd == REG_W'(r)))
                    cnt[r] <= LAT;
                else if (cnt[r] != 3'd0)
                    cnt[r] <= cnt[r] - 3'd1;
            end
        end
    end

    always_comb begin
        PC_stall    = mem_busy | haz;
        IF_ID_stall = mem_busy | haz;
        ID_flush    = ~mem_busy & haz;
        IF_flush    = ~mem_busy & ~haz & update_PC;
        pipe_freeze = mem_busy;
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (haz && !mem_busy && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised successor to the pipeline hazard detector. It generates the same stall and flush controls for load-to-use, B and BR hazards. It adds a per-register countdown scoreboard, so loads with a multi-cycle data-memory latency are stalled correctly, and a pipeline-wide freeze while data memory is busy. It sits in the ID stage and drives the PC, IF/ID and ID/EX control and the back-end stall.

## Interface
Parameters:
- REG_W, 4, register-ID width; the scoreboard holds 2**REG_W entries, and entry 0 is never tracked.
- LOAD_LAT, 0, extra cycles after a load leaves EX before its data is forwardable to ID. Legal range is 0..7; 0 equals the classic 5-stage timing.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- SrcReg1, SrcReg2  in  REG_W  Rs / Rt of the instruction in ID.
- MemWrite  in  1  the ID instruction is a store; SrcReg2 is its store data.
- Branch, BR  in  1  the ID instruction is a branch; BR qualifies a register branch.
- update_PC  in  1  the branch resolved in ID redirects the PC.
- ID_EX_RegWrite, ID_EX_MemEnable, ID_EX_MemWrite, ID_EX_Z_en, ID_EX_NV_en  in  1  control fields of the instruction in EX.
- ID_EX_reg_rd  in  REG_W  destination register of the instruction in EX.
- EX_MEM_RegWrite  in  1  write enable of the instruction in MEM.
- EX_MEM_reg_rd  in  REG_W  destination register of the instruction in MEM.
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- PC_stall, IF_ID_stall, ID_flush, IF_flush  out  1  front-end controls.
- pipe_freeze  out  1  hold the ID/EX, EX/MEM and MEM/WB registers.
- stall_cycles  out  32  present only with HAZ_PERF_CNT_EN.

## Operation
- ex_load = ID_EX_MemEnable & ~ID_EX_MemWrite & (ID_EX_reg_rd != 0).
- Scoreboard: cnt[r] is 3 bits per register.
  - Load: if the pipeline is not frozen and ex_load, then cnt[ID_EX_reg_rd] <= LOAD_LAT. This overrides any decrement of the same entry.
  - Decrement: every other nonzero entry decrements when the pipeline is not frozen.
  - Hold: all entries hold while frozen.
  - Entry 0 stays 0.
- busy(r) = (ex_load & ID_EX_reg_rd==r) | (cnt[r] != 0), for r != 0.
- Load-to-use hazard: busy(SrcReg1) or busy(SrcReg2), with one exception.
  - When MemWrite=1, SrcReg2 uses the store-data rule: stall iff (ex_load & ID_EX_reg_rd==SrcReg2 & LOAD_LAT>0) | cnt[SrcReg2]>1.
  - This store-data rule reflects MEM-MEM forwarding.
- B hazard: Branch & (ID_EX_Z_en | ID_EX_NV_en).
- BR hazard: Branch & BR & (flag hazard | EX write to SrcReg1 | MEM write to SrcReg1 | cnt[SrcReg1]!=0). The EX and MEM write terms require the destination to be nonzero.
- haz = load-to-use | B hazard | BR hazard.
- Freeze (mem_busy=1):
  - PC_stall = IF_ID_stall = pipe_freeze = 1.
  - ID_flush = IF_flush = 0.
  - The hazard terms are masked.
- Not frozen:
  - PC_stall = IF_ID_stall = ID_flush = haz.
  - IF_flush = ~haz & update_PC.
  - pipe_freeze = 0.

## Timing
- All outputs are combinational from the inputs and the scoreboard state; no output is registered.
- Reset: after a rst cycle all cnt = 0. With all-zero inputs, every output is 0 and stall_cycles = 0.
- A general consumer of a load's register stalls for 1+LOAD_LAT cycles. A store-data consumer stalls for LOAD_LAT cycles.
- rst asserted mid-stall clears every counter at that edge, regardless of mem_busy.
- Simultaneous load into an entry with a nonzero count: the entry takes LOAD_LAT, which is never less than the decremented value.
- Entries count independently; several can be nonzero at once.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cycles increments on each clk edge where haz=1 and mem_busy=0.
  - It saturates at 32'hFFFF_FFFF and is cleared by rst.
- HAZ_PERF_CNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- LOAD_LAT=0, load r3 in EX, ID reads SrcReg1=3 -> one stall cycle, matching the 5-stage behaviour. Same case with MemWrite=1 and SrcReg2=3 -> no stall.
- LOAD_LAT=2, load r5 in EX, ID reads SrcReg1=5 -> IF_ID_stall=ID_flush=1 for 3 cycles, released on the 4th. As a store-data operand (SrcReg2=5, MemWrite=1) -> 2 stall cycles.
- LOAD_LAT=2, load r5 then mem_busy=1 for 4 cycles mid-count -> pipe_freeze=1, ID_flush=0, cnt[5] holds. Stall resumes for the remaining cycles after mem_busy drops.
- Branch=BR=1, SrcReg1=7, EX_MEM write r7 -> stall 1 cycle. Branch=1 with ID_EX_Z_en=1 -> stall. No hazard with update_PC=1 -> IF_flush=1.
- Load to r0 or with rd=0 -> no stall; cnt stays 0. rst asserted while cnt[4]=2 -> all outputs 0 on the next cycle.
- HAZ_PERF_CNT_EN: 3 data-hazard stalls plus 4 frozen cycles -> stall_cycles=3.
